// File: rtl/vending_ctrl_param_if.sv
// Vending controller bus: coin acceptor inputs, dispenser and hopper handshakes.
// master = controller side, slave = acceptor/dispenser side. COIN_REJECT_EN adds coin_reject.
interface vending_ctrl_param_if #(
  parameter int CREDIT_W = 4
);
  logic [1:0]          cash_in;
  logic                cancel;
  logic                vend_ack;
  logic                change_ready;
  logic                coin_accept;
  logic                purchase;
  logic                change_valid;
  logic [CREDIT_W-1:0] credit;
`ifdef COIN_REJECT_EN
  logic                coin_reject;

  modport master (
    input  cash_in, cancel, vend_ack, change_ready,
    output coin_accept, purchase, change_valid,
    output credit, coin_reject
  );
  modport slave (
    output cash_in, cancel, vend_ack, change_ready,
    input  coin_accept, purchase, change_valid,
    input  credit, coin_reject
  );
`else
  modport master (
    input  cash_in, cancel, vend_ack, change_ready,
    output coin_accept, purchase, change_valid, credit
  );
  modport slave (
    output cash_in, cancel, vend_ack, change_ready,
    input  coin_accept, purchase, change_valid, credit
  );
`endif
endinterface

// File: rtl/vending_ctrl_param.sv
// Parametrised vending controller: credit accumulation, held vend request, change payout.
// Ports: clk, reset (async, active-high), bus (vending_ctrl_param_if.master). Macro: COIN_REJECT_EN.
module vending_ctrl_param #(
  parameter int PRICE     = 3,
  parameter int CREDIT_W  = 4,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2,
  parameter int COIN3_VAL = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  vending_ctrl_param_if.master  bus
);
  localparam int SW = CREDIT_W + 1;
  localparam logic [SW-1:0] MAX_C = SW'((1 << CREDIT_W) - 1);
  localparam logic [SW-1:0] PRICE_C = SW'(PRICE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                purchase_q, purchase_d;
  logic                change_valid_q, change_valid_d;

  logic [SW-1:0] coin_v;
  logic [SW-1:0] sum;
  logic          coin_in;
  logic          ovf;
  logic          coin_accept;

  always_comb begin
    coin_v = '0;
    case (bus.cash_in)
      2'b01:   coin_v = SW'(COIN1_VAL);
      2'b10:   coin_v = SW'(COIN2_VAL);
      2'b11:   coin_v = SW'(COIN3_VAL);
      default: coin_v = '0;
    endcase
  end

  assign coin_in = bus.cash_in != 2'b00;
  assign sum     = {1'b0, credit_q} + coin_v;
  assign ovf     = sum > MAX_C;
  assign coin_accept = (state_q == IDLE) || (state_q == ACCUM);

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    purchase_d     = purchase_q;
    change_valid_d = change_valid_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (bus.cancel) begin
          // Cancel wins over reaching the price: bank the coin, refund all.
          if (coin_in && !ovf)
            credit_d = CREDIT_W'(sum);
          if (credit_d != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (coin_in && !ovf) begin
          if (sum >= PRICE_C) begin
            credit_d   = CREDIT_W'(sum - PRICE_C);
            purchase_d = 1'b1;
            state_d    = VEND;
          end else begin
            credit_d = CREDIT_W'(sum);
            state_d  = ACCUM;
          end
        end
      end
      VEND: begin
        if (bus.vend_ack) begin
          purchase_d = 1'b0;
          if (credit_q != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE: begin
        if (credit_q == '0) begin
          state_d        = IDLE;
          change_valid_d = 1'b0;
        end else if (change_valid_q && bus.change_ready) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            change_valid_d = 1'b0;
            state_d        = IDLE;
          end
        end
      end
      default: begin
        state_d        = IDLE;
        credit_d       = '0;
        purchase_d     = 1'b0;
        change_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      purchase_q     <= 1'b0;
      change_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      purchase_q     <= purchase_d;
      change_valid_q <= change_valid_d;
    end
  end

  assign bus.coin_accept  = coin_accept;
  assign bus.purchase     = purchase_q;
  assign bus.change_valid = change_valid_q;
  assign bus.credit       = credit_q;

`ifdef COIN_REJECT_EN
  logic coin_reject_q, coin_reject_d;

  // A coin is bounced on overflow, or whenever the controller is busy.
  assign coin_reject_d = coin_in && (!coin_accept || ovf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      coin_reject_q <= 1'b0;
    else
      coin_reject_q <= coin_reject_d;
  end

  assign bus.coin_reject = coin_reject_q;
`endif
endmodule

// File: tb/tb_vending_ctrl_param.sv
// Bench for vending_ctrl_param: vector table with scoreboard queue plus reset sequences.
// dut0 uses default parameters, dut1 uses PRICE=12.
module tb_vending_ctrl_param;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  vending_ctrl_param_if #(.CREDIT_W(4)) if0 ();
  vending_ctrl_param_if #(.CREDIT_W(4)) if1 ();

  vending_ctrl_param dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  vending_ctrl_param #(.PRICE(12)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1)
  );

`ifdef COIN_REJECT_EN
  localparam bit REJ_EN = 1'b1;
`else
  localparam bit REJ_EN = 1'b0;
`endif

  typedef struct {
    bit         sel;
    logic [1:0] cash;
    bit         cnl;
    bit         ack;
    bit         rdy;
    bit         acc;
    bit         pur;
    bit         cv;
    logic [3:0] cr;
    bit         rej;
  } vec_t;

  typedef struct {
    bit         sel;
    int         id;
    logic [7:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   ncmp = 0;
  int   nerr = 0;

  localparam int SPLIT = 26;

  function automatic vec_t v(
    bit sel, logic [1:0] cash, bit cnl, bit ack, bit rdy,
    bit acc, bit pur, bit cv, logic [3:0] cr, bit rej
  );
    vec_t x;
    x.sel = sel; x.cash = cash; x.cnl = cnl;
    x.ack = ack; x.rdy = rdy; x.acc = acc;
    x.pur = pur; x.cv = cv; x.cr = cr; x.rej = rej;
    return x;
  endfunction

  function automatic logic [7:0] actual(bit sel);
    logic r0, r1;
`ifdef COIN_REJECT_EN
    r0 = if0.coin_reject;
    r1 = if1.coin_reject;
`else
    r0 = 1'b0;
    r1 = 1'b0;
`endif
    if (sel)
      return {if1.coin_accept, if1.purchase,
              if1.change_valid, if1.credit, r1};
    return {if0.coin_accept, if0.purchase,
            if0.change_valid, if0.credit, r0};
  endfunction

  task automatic cmp(string name, logic [7:0] act,
                     logic [7:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got acc/pur/cv/cr/rej=%b_%b_%b_%0d_%b want %b_%b_%b_%0d_%b",
               name, act[7], act[6], act[5], act[4:1], act[0],
               exp[7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic set_in(bit sel, logic [1:0] cash,
                        bit cnl, bit ack, bit rdy);
    if0.cash_in = 2'b00; if0.cancel = 1'b0;
    if0.vend_ack = 1'b0; if0.change_ready = 1'b0;
    if1.cash_in = 2'b00; if1.cancel = 1'b0;
    if1.vend_ack = 1'b0; if1.change_ready = 1'b0;
    if (sel) begin
      if1.cash_in = cash; if1.cancel = cnl;
      if1.vend_ack = ack; if1.change_ready = rdy;
    end else begin
      if0.cash_in = cash; if0.cancel = cnl;
      if0.vend_ack = ack; if0.change_ready = rdy;
    end
  endtask

  task automatic drive(vec_t x, int id);
    sb_t e;
    @(negedge clk);
    set_in(x.sel, x.cash, x.cnl, x.ack, x.rdy);
    e.sel = x.sel;
    e.id  = id;
    e.exp = {x.acc, x.pur, x.cv, x.cr, x.rej & REJ_EN};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      ncmp++;
      nerr++;
      $display("FAIL sb_empty vec%0d: got 0 entries want 1", id);
    end else begin
      e = sbq.pop_front();
      cmp($sformatf("vec%0d", e.id), actual(e.sel), e.exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // dut0, price 3
    tbl.push_back(v(0,1,0,0,0, 1,0,0,1,0));
    tbl.push_back(v(0,1,0,0,0, 1,0,0,2,0));
    tbl.push_back(v(0,1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(0,0,0,1,0, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,0,0,0,0));
    tbl.push_back(v(0,3,0,0,0, 0,1,0,2,0));
    tbl.push_back(v(0,0,0,1,1, 0,0,1,2,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(v(0,2,0,0,0, 1,0,0,2,0));
    tbl.push_back(v(0,0,1,0,0, 0,0,1,2,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,0, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(v(0,3,0,0,0, 0,1,0,2,0));
    tbl.push_back(v(0,3,1,0,0, 0,1,0,2,1));
    tbl.push_back(v(0,3,0,1,0, 0,0,1,2,1));
    tbl.push_back(v(0,3,1,1,0, 0,0,1,2,1));
    tbl.push_back(v(0,0,0,0,1, 0,0,1,1,0));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,0,0));
    tbl.push_back(v(0,0,1,0,0, 1,0,0,0,0));
    tbl.push_back(v(0,3,1,0,0, 0,0,1,5,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,1,4,0));
    tbl.push_back(v(0,0,0,0,1, 0,0,1,3,0));
    // after mid-change reset
    tbl.push_back(v(0,0,0,0,1, 1,0,0,0,0));
    // dut1, price 12
    tbl.push_back(v(1,3,0,0,0, 1,0,0,5,0));
    tbl.push_back(v(1,3,0,0,0, 1,0,0,10,0));
    tbl.push_back(v(1,1,0,0,0, 1,0,0,11,0));
    tbl.push_back(v(1,3,0,0,0, 1,0,0,11,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,11,0));
    tbl.push_back(v(1,1,0,0,0, 0,1,0,0,0));
    tbl.push_back(v(1,0,0,1,0, 1,0,0,0,0));
    tbl.push_back(v(1,0,0,1,1, 1,0,0,0,0));

    reset = 1'b1;
    set_in(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    cmp("rst0", actual(1'b0), 8'b1000_0000);
    cmp("rst1", actual(1'b1), 8'b1000_0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < SPLIT; i++)
      drive(tbl[i], i);

    // Reset while paying out change with credit 3.
    #2;
    cmp("pre_rst", actual(1'b0),
        {1'b0, 1'b0, 1'b1, 4'd3, 1'b0});
    reset = 1'b1;
    #1;
    cmp("mid_rst", actual(1'b0), 8'b1000_0000);
    @(posedge clk);
    #1;
    cmp("hold_rst", actual(1'b0), 8'b1000_0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = SPLIT; i < tbl.size(); i++)
      drive(tbl[i], i);

    if (sbq.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL sb_left: got %0d want 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
